// File: rtl/square_move_collector_pkg.sv
// Shared definitions for the square move collector: word geometry, empty-move
// encoding, direction indices, piece/colour codes and the collector state type.
package square_move_collector_pkg;

  localparam int NUM_DIR = 16;
  localparam int MOVE_W  = 24;
  localparam int IDX_W   = 4;

  localparam logic [MOVE_W-1:0] EMPTY_MOVE = 24'h000000;

  // Sliding / king / pawn directions
  localparam logic [IDX_W-1:0] DIR_U   = 4'd0;
  localparam logic [IDX_W-1:0] DIR_D   = 4'd1;
  localparam logic [IDX_W-1:0] DIR_L   = 4'd2;
  localparam logic [IDX_W-1:0] DIR_R   = 4'd3;
  localparam logic [IDX_W-1:0] DIR_UL  = 4'd4;
  localparam logic [IDX_W-1:0] DIR_UR  = 4'd5;
  localparam logic [IDX_W-1:0] DIR_DL  = 4'd6;
  localparam logic [IDX_W-1:0] DIR_DR  = 4'd7;
  // Knight jumps
  localparam logic [IDX_W-1:0] DIR_UUL = 4'd8;
  localparam logic [IDX_W-1:0] DIR_UUR = 4'd9;
  localparam logic [IDX_W-1:0] DIR_LLU = 4'd10;
  localparam logic [IDX_W-1:0] DIR_RRU = 4'd11;
  localparam logic [IDX_W-1:0] DIR_DDL = 4'd12;
  localparam logic [IDX_W-1:0] DIR_DDR = 4'd13;
  localparam logic [IDX_W-1:0] DIR_LLD = 4'd14;
  localparam logic [IDX_W-1:0] DIR_RRD = 4'd15;

  // Piece and colour codes used by the square logic feeding this block
  typedef enum logic [2:0] {
    PIECE_NONE, PIECE_PAWN, PIECE_KNIGHT, PIECE_BISHOP,
    PIECE_ROOK, PIECE_QUEEN, PIECE_KING
  } piece_t;

  typedef enum logic {COLOUR_WHITE, COLOUR_BLACK} colour_t;

  // Collector FSM states
  //  state   | meaning
  //  ST_IDLE | waiting for a snapshot request
  //  ST_EMIT | streaming pending moves, lowest direction first
  //  ST_DONE | one-cycle completion pulse
  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_t;

endpackage

// File: rtl/square_move_collector_if.sv
// Move stream handshake between the collector and the move-list stage.
interface square_move_collector_if;

  logic [square_move_collector_pkg::MOVE_W-1:0] move_out;
  logic [square_move_collector_pkg::IDX_W-1:0]  move_dir;
  logic                                         move_valid;
  logic                                         move_ready;

  modport master (output move_out, output move_dir, output move_valid, input move_ready);
  modport slave  (input move_out, input move_dir, input move_valid, output move_ready);

endinterface

// File: rtl/square_move_collector_prio_enc16.sv
// Lowest-set-bit encoder over the 16-entry pending mask.
module square_move_collector_prio_enc16 (
  input  logic [15:0] pending,
  output logic        any,
  output logic [3:0]  idx
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) idx = 4'(i);
    end
  end

  assign any = |pending;

endmodule

// File: rtl/square_move_collector.sv
// Snapshots one square's 16 direction move words, drops empty ones and streams
// the rest over a valid/ready handshake, lowest direction index first.
module square_move_collector
  import square_move_collector_pkg::*;
(
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      load,
  input  logic                      flush,
  input  logic [NUM_DIR*MOVE_W-1:0] moves_in,
  square_move_collector_if.master   mv,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W:0]            move_count
);

  localparam logic [IDX_W:0]   CNT_ONE    = 1;
  localparam logic [NUM_DIR-1:0] ONEHOT_LSB = 1;

  state_t               state, next_state;
  logic [MOVE_W-1:0]    words [NUM_DIR];
  logic [NUM_DIR-1:0]   pending;
  logic [NUM_DIR-1:0]   cap_mask;
  logic [NUM_DIR-1:0]   sel_onehot;
  logic [IDX_W-1:0]     sel;
  logic                 sel_any;
  logic                 cap_any;
  logic                 capture;
  logic                 fire;
  logic                 last_move;

  square_move_collector_prio_enc16 u_prio (
    .pending (pending),
    .any     (sel_any),
    .idx     (sel)
  );

  // Non-empty mask of the incoming words, used only at capture time.
  always_comb begin
    cap_mask = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      cap_mask[i] = (moves_in[i*MOVE_W +: MOVE_W] != EMPTY_MOVE);
    end
  end

  assign cap_any    = |cap_mask;
  assign capture    = (state == ST_IDLE) && load && !flush;
  assign fire       = (state == ST_EMIT) && sel_any && mv.move_ready && !flush;
  assign sel_onehot = ONEHOT_LSB << sel;
  assign last_move  = ((pending & ~sel_onehot) == '0);

  // State register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and output decode; outputs depend on registers only, never on moves_in.
  always_comb begin
    next_state    = state;
    mv.move_valid = 1'b0;
    mv.move_out   = '0;
    mv.move_dir   = '0;
    busy          = (state != ST_IDLE);
    done          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (capture) next_state = cap_any ? ST_EMIT : ST_DONE;
      end
      ST_EMIT: begin
        mv.move_valid = 1'b1;
        mv.move_out   = words[sel];
        mv.move_dir   = sel;
        if (fire && last_move) next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (flush) next_state = ST_IDLE;
  end

  // Snapshot words, pending mask and accepted-move counter.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_DIR; i++) words[i] <= '0;
      pending    <= '0;
      move_count <= '0;
    end else if (flush) begin
      pending <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_DIR; i++) words[i] <= moves_in[i*MOVE_W +: MOVE_W];
      pending    <= cap_mask;
      move_count <= '0;
    end else if (fire) begin
      pending[sel] <= 1'b0;
      move_count   <= move_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_square_move_collector.sv
// Self-checking bench: table of snapshots plus hand-written corner sequences,
// with a queue scoreboard checking every accepted move.
module tb_square_move_collector;

  logic         clk;
  logic         clear;
  logic         load;
  logic         flush;
  logic [383:0] moves_in;
  logic         busy;
  logic         done;
  logic [4:0]   move_count;

  square_move_collector_if mif ();

  square_move_collector dut (
    .clk        (clk),
    .clear      (clear),
    .load       (load),
    .flush      (flush),
    .moves_in   (moves_in),
    .mv         (mif),
    .busy       (busy),
    .done       (done),
    .move_count (move_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dir;
    logic [23:0] word;
  } exp_t;

  typedef struct {
    logic [383:0] moves;
    int           exp_cnt;
    string        name;
  } vec_t;

  exp_t  q[$];
  int    total = 0;
  int    bad   = 0;

  logic        hold_prev = 1'b0;
  logic [23:0] prev_out;
  logic [3:0]  prev_dir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [383:0] put(input logic [383:0] m, input int i, input logic [23:0] w);
    logic [383:0] r;
    r = m;
    r[i*24 +: 24] = w;
    return r;
  endfunction

  // Scoreboard: each accepted move must match the next expected one; stalled outputs must hold.
  always @(negedge clk) begin
    if (clear) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && mif.move_valid) begin
        total++;
        if (mif.move_out !== prev_out || mif.move_dir !== prev_dir) begin
          bad++;
          $display("FAIL stall_hold: got dir=%0d word=%h expected dir=%0d word=%h",
                   mif.move_dir, mif.move_out, prev_dir, prev_out);
        end
      end
      if (mif.move_valid && mif.move_ready && !flush) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_move: got dir=%0d word=%h expected none", mif.move_dir, mif.move_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (mif.move_dir !== e.dir || mif.move_out !== e.word) begin
            bad++;
            $display("FAIL move: got dir=%0d word=%h expected dir=%0d word=%h",
                     mif.move_dir, mif.move_out, e.dir, e.word);
          end
        end
      end
      hold_prev = mif.move_valid && !mif.move_ready && !flush;
      prev_out  = mif.move_out;
      prev_dir  = mif.move_dir;
    end
  end

  // Load a snapshot, push its expected stream, then wait (bounded) for done.
  task automatic snapshot(input logic [383:0] m, input logic [31:0] rdy_pat, input bit hold_load,
                          input logic [383:0] alt, input int exp_cnt, input int exp_done,
                          input string name);
    int got;
    for (int i = 0; i < 16; i++) begin
      if (m[i*24 +: 24] != 24'h0) q.push_back('{dir: 4'(i), word: m[i*24 +: 24]});
    end
    @(posedge clk); #1;
    moves_in = m;
    load     = 1'b1;
    mif.move_ready = rdy_pat[0];
    @(posedge clk); #1;
    if (hold_load) moves_in = alt;
    else           load     = 1'b0;
    mif.move_ready = rdy_pat[1];
    got = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        got = k;
        chk({name, "_busy_in_done"}, 32'(busy), 32'd1);
        load = 1'b0;
        break;
      end
      @(posedge clk); #1;
      mif.move_ready = (k + 1 < 32) ? rdy_pat[k+1] : 1'b1;
    end
    if (got < 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done expected done at cycle %0d", name, exp_done);
    end else begin
      chk({name, "_done_cycle"}, 32'(got), 32'(exp_done));
    end
    chk({name, "_count"}, 32'(move_count), 32'(exp_cnt));
    chk({name, "_queue_left"}, 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    mif.move_ready = 1'b1;
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_done_pulse_len"}, 32'(done), 32'd0);
    q.delete();
  endtask

  vec_t         vecs [6];
  logic [383:0] scen1;
  logic [383:0] all_nz;
  logic [383:0] tmp;

  initial begin
    clear = 1'b1;
    load  = 1'b0;
    flush = 1'b0;
    moves_in = '0;
    mif.move_ready = 1'b1;

    scen1 = '0;
    scen1 = put(scen1, 0, 24'h00A1B2);
    scen1 = put(scen1, 6, 24'h0C0303);
    scen1 = put(scen1, 9, 24'h12345A);
    all_nz = '0;
    for (int i = 0; i < 16; i++) all_nz = put(all_nz, i, 24'h010101 * 24'(i + 1));

    vecs[0] = '{moves: scen1, exp_cnt: 3, name: "scen1"};
    vecs[1] = '{moves: '0, exp_cnt: 0, name: "all_empty"};
    vecs[2] = '{moves: all_nz, exp_cnt: 16, name: "all_full"};
    tmp = '0;
    for (int i = 8; i < 16; i++) tmp = put(tmp, i, 24'hF00000 | 24'(i));
    vecs[3] = '{moves: tmp, exp_cnt: 8, name: "knights"};
    tmp = '0;
    tmp = put(tmp, 15, 24'h800000);
    vecs[4] = '{moves: tmp, exp_cnt: 1, name: "only_rrd"};
    tmp = '0;
    for (int i = 1; i < 16; i += 2) tmp = put(tmp, i, 24'h000001 << i);
    vecs[5] = '{moves: tmp, exp_cnt: 8, name: "odd_dirs"};

    #12;
    chk("rst_valid", 32'(mif.move_valid), 32'd0);
    chk("rst_out", 32'(mif.move_out), 32'd0);
    chk("rst_dir", 32'(mif.move_dir), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(move_count), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;

    for (int v = 0; v < 6; v++) begin
      snapshot(vecs[v].moves, 32'hFFFF_FFFF, 1'b0, '0, vecs[v].exp_cnt, vecs[v].exp_cnt + 1, vecs[v].name);
    end

    // ready 1-0-0-1: second move stalls two cycles
    snapshot(scen1, 32'hFFFF_FFF3, 1'b0, '0, 3, 6, "ready_toggle");

    // load held with different words during the stream
    snapshot(scen1, 32'hFFFF_FFFF, 1'b1, all_nz, 3, 4, "load_hold");

    // flush in the second EMIT cycle
    q.push_back('{dir: 4'd0, word: 24'h00A1B2});
    @(posedge clk); #1;
    moves_in = scen1;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(mif.move_valid), 32'd0);
    chk("flush_count", 32'(move_count), 32'd1);
    chk("flush_queue", 32'(q.size()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_no_done", 32'(done), 32'd0);
    end
    q.delete();

    // flush and load together in IDLE: no capture
    @(posedge clk); #1;
    moves_in = all_nz;
    load = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("ldfl_busy", 32'(busy), 32'd0);
    chk("ldfl_valid", 32'(mif.move_valid), 32'd0);
    chk("ldfl_count", 32'(move_count), 32'd1);

    // clear mid-stream
    for (int i = 0; i < 16; i++) q.push_back('{dir: 4'(i), word: all_nz[i*24 +: 24]});
    @(posedge clk); #1;
    moves_in = all_nz;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_clear_count", 32'(move_count), 32'd2);
    clear = 1'b1;
    #1;
    chk("clr_valid", 32'(mif.move_valid), 32'd0);
    chk("clr_out", 32'(mif.move_out), 32'd0);
    chk("clr_dir", 32'(mif.move_dir), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_count", 32'(move_count), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    q.delete();
    @(negedge clk);
    chk("post_clear_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
